ofdm_frame_sync_ctrl: RTL and testbench
=======================================

# ofdm_frame_sync_ctrl

Frame-level sequencer behind the two OFDM preamble correlators. Consumes the `find_preamble_a` / `find_preamble_b` hits and the receiver's sample strobe, and checks that B follows A within a sample window. It then opens a data window of `N_SYM` symbols and tags each sample with symbol and sample indices for the downstream FFT/demapper. It drives the `o_flaf_wayt_data` "waiting for frame" flag.

## Interface
Parameters:
- `SYM_LEN`, 64: useful samples per data symbol.
- `CP_LEN`, 16: cyclic-prefix samples per symbol; used only with the macro.
- `N_SYM`, 8: data symbols per frame; must be 1..256.
- `AB_MIN`, 60: earliest accepted A→B distance, in qualified samples.
- `AB_MAX`, 68: latest accepted A→B distance; must be ≥ `AB_MIN` and ≤ 255.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `en` in 1: block enable.
- `valid` in 1: input sample strobe.
- `find_preamble_a` in 1: preamble A hit, aligned with `valid`.
- `find_preamble_b` in 1: preamble B hit, aligned with `valid`.
- `o_flaf_wayt_data` out 1: high while in WAIT_A.
- `o_frame_start` out 1: one-cycle pulse when B is accepted.
- `o_data_valid` out 1: the current input sample is a frame data sample.
- `o_sym_idx` out 8: data symbol index, 0..N_SYM-1.
- `o_smp_idx` out 8: useful-sample index within the symbol, 0..SYM_LEN-1.
- `o_frame_done` out 1: one-cycle pulse on the last data sample.
- `o_err_timeout` out 1: one-cycle pulse when the B window expires.

## Operation
- Qualified sample `q = valid & en`. All counting and all state transitions occur only on `q`.
- `en = 0` freezes the state and every counter. While `en = 0`, the pulse outputs and `o_data_valid` are 0.
- FSM states: WAIT_A, WAIT_B, DATA.
- WAIT_A:
  - `o_flaf_wayt_data = 1`.
  - `q & find_preamble_a` → WAIT_B with `gap = 0`.
  - `find_preamble_b` is ignored.
- WAIT_B: each `q` computes `k = gap + 1`, the distance from A.
  - If `find_preamble_b` and `AB_MIN ≤ k ≤ AB_MAX`: go to DATA, pulse `o_frame_start`, clear `sym` and `smp`.
  - Else if `find_preamble_a`: re-anchor, `gap = 0`, stay in WAIT_B. Out-of-window B is ignored. A simultaneous in-window B wins over A.
  - Else if `k == AB_MAX`: go to WAIT_A and pulse `o_err_timeout`.
  - Else `gap = k`.
- DATA: each `q` is one frame sample.
  - The symbol position counter wraps at the symbol period and increments `sym`.
  - On the last sample of symbol `N_SYM-1`, pulse `o_frame_done` (coincident with `o_data_valid`) and go to WAIT_A.
  - Preamble hits are ignored in DATA.
- `o_sym_idx` and `o_smp_idx` are valid only when `o_data_valid = 1`; otherwise they hold their last value.
- Reset (`reset = 0` at a clock edge, in any state) forces WAIT_A and clears all counters.
  - Reset values: `o_flaf_wayt_data = 1`; all other outputs 0.

## Timing
- All outputs are registered. The response to the qualifying input cycle appears one clock later.
- `o_frame_start` is high in the cycle after the accepted B sample.
- The first `o_data_valid` corresponds to the first `q` after B, and appears one clock after that `q`.
- `o_data_valid` is high for exactly one cycle per qualified data sample. Gaps in `valid` produce gaps in `o_data_valid`; indices do not advance across gaps.
- `o_flaf_wayt_data` deasserts the cycle after A is accepted. It reasserts the cycle after `o_frame_done` or `o_err_timeout`.
- A new A is accepted on the first `q` after returning to WAIT_A, with zero dead cycles.

## Configuration
- `OFDM_FRAME_CP_STRIP_EN` defined:
  - Symbol period is `CP_LEN + SYM_LEN` samples.
  - The first `CP_LEN` samples of each symbol are counted with `o_data_valid = 0`.
  - `o_smp_idx` counts 0..SYM_LEN-1 over the useful part only.
- `OFDM_FRAME_CP_STRIP_EN` undefined:
  - Symbol period is `SYM_LEN`, and every DATA sample is flagged.
  - `CP_LEN` is unused.

## Test plan
Defaults throughout; `valid` continuous unless stated.
1. A at q#0, B at q#64, macro off → `o_frame_start` once, then 512 `o_data_valid` cycles with `o_sym_idx` 0..7 and `o_smp_idx` 0..63. `o_frame_done` with sample (7,63); `o_flaf_wayt_data` back to 1.
2. A, no B → `o_err_timeout` one cycle after q#68; no `o_data_valid`.
3. A, B at k=40 (ignored), B at k=64 → a single frame starts after k=64.
4. A, second A at k=30, B at k=64 from first A (k=34, ignored) → `o_err_timeout` after k=68 counted from the second A.
5. Insert 3-cycle `valid = 0` and 2-cycle `en = 0` gaps inside DATA → `o_data_valid` total still 512 and indices continuous. With the macro: 640 DATA samples, 512 flagged, first 16 of each symbol unflagged.
6. `reset = 0` during DATA at symbol 3 → next cycle all outputs at reset values. A new A/B pair afterwards starts a clean frame from (0,0).

Source files
------------

// File: rtl/ofdm_frame_sync_ctrl.sv
// ============================================================================
// ofdm_frame_sync_ctrl
//
// Frame-level sequencer for an OFDM receiver. It waits for a preamble-A hit,
// then for a preamble-B hit that lands AB_MIN..AB_MAX qualified samples after
// A. After that it opens a data window of N_SYM symbols and tags every data
// sample with its symbol and useful-sample index for the FFT/demapper.
//
// Build option: define OFDM_FRAME_CP_STRIP_EN to make each symbol
// CP_LEN + SYM_LEN samples long. The cyclic-prefix samples are counted but not
// flagged. With the macro undefined, every DATA sample is a useful sample.
//
// Ports
//   clk               : clock
//   reset             : synchronous, active-low reset
//   en                : block enable (freezes state and counters when low)
//   valid             : input sample strobe
//   find_preamble_a   : preamble A hit, aligned with valid
//   find_preamble_b   : preamble B hit, aligned with valid
//   o_flaf_wayt_data  : high while waiting for preamble A
//   o_frame_start     : one-cycle pulse after the accepted B sample
//   o_data_valid      : current sample is a (useful) frame data sample
//   o_sym_idx         : data symbol index, valid with o_data_valid
//   o_smp_idx         : useful-sample index, valid with o_data_valid
//   o_frame_done      : one-cycle pulse with the last data sample
//   o_err_timeout     : one-cycle pulse when the B window expires
//
// All outputs are registered: they reflect the qualified sample of the
// previous clock.
// ============================================================================
module ofdm_frame_sync_ctrl #(
    parameter int SYM_LEN = 64,
    parameter int CP_LEN  = 16,
    parameter int N_SYM   = 8,
    parameter int AB_MIN  = 60,
    parameter int AB_MAX  = 68
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       valid,
    input  logic       find_preamble_a,
    input  logic       find_preamble_b,
    output logic       o_flaf_wayt_data,
    output logic       o_frame_start,
    output logic       o_data_valid,
    output logic [7:0] o_sym_idx,
    output logic [7:0] o_smp_idx,
    output logic       o_frame_done,
    output logic       o_err_timeout
);

`ifdef OFDM_FRAME_CP_STRIP_EN
    localparam int PERIOD = CP_LEN + SYM_LEN;
`else
    localparam int PERIOD = SYM_LEN;
`endif

    // The position counter is sized for the longer (CP-stripping) symbol so
    // both builds share one counter width.
    localparam int              POS_W    = $clog2(SYM_LEN + CP_LEN + 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(PERIOD - 1);
`ifdef OFDM_FRAME_CP_STRIP_EN
    localparam logic [POS_W-1:0] CP_POS   = POS_W'(CP_LEN);
`endif
    localparam logic [7:0]      SYM_LAST = 8'(N_SYM - 1);
    localparam logic [7:0]      K_MIN    = 8'(AB_MIN);
    localparam logic [7:0]      K_MAX    = 8'(AB_MAX);

    typedef enum logic [1:0] {
        WAIT_A,
        WAIT_B,
        DATA
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       gap_reg, gap_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic [7:0]       sym_reg, sym_next;

    logic             flag_reg, flag_next;
    logic             start_reg, start_next;
    logic             dv_reg, dv_next;
    logic [7:0]       sym_idx_reg, sym_idx_next;
    logic [7:0]       smp_idx_reg, smp_idx_next;
    logic             done_reg, done_next;
    logic             timeout_reg, timeout_next;

    logic             q;
    logic [7:0]       k;

    assign q = valid & en;
    // Distance of the current sample from the anchoring A hit.
    assign k = gap_reg + 8'd1;

    always_comb begin
        state_next   = state_reg;
        gap_next     = gap_reg;
        pos_next     = pos_reg;
        sym_next     = sym_reg;
        start_next   = 1'b0;
        dv_next      = 1'b0;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        sym_idx_next = sym_idx_reg;
        smp_idx_next = smp_idx_reg;

        if (q) begin
            unique case (state_reg)
                WAIT_A: begin
                    if (find_preamble_a) begin
                        state_next = WAIT_B;
                        gap_next   = 8'd0;
                    end
                end
                WAIT_B: begin
                    // In-window B has priority over a re-anchoring A.
                    if (find_preamble_b && (k >= K_MIN) && (k <= K_MAX)) begin
                        state_next = DATA;
                        start_next = 1'b1;
                        pos_next   = '0;
                        sym_next   = 8'd0;
                    end else if (find_preamble_a) begin
                        gap_next = 8'd0;
                    end else if (k == K_MAX) begin
                        state_next   = WAIT_A;
                        timeout_next = 1'b1;
                    end else begin
                        gap_next = k;
                    end
                end
                DATA: begin
`ifdef OFDM_FRAME_CP_STRIP_EN
                    if (pos_reg >= CP_POS) begin
                        dv_next      = 1'b1;
                        sym_idx_next = sym_reg;
                        smp_idx_next = 8'(pos_reg - CP_POS);
                    end
`else
                    dv_next      = 1'b1;
                    sym_idx_next = sym_reg;
                    smp_idx_next = 8'(pos_reg);
`endif
                    if (pos_reg == POS_LAST) begin
                        pos_next = '0;
                        if (sym_reg == SYM_LAST) begin
                            done_next  = 1'b1;
                            sym_next   = 8'd0;
                            state_next = WAIT_A;
                        end else begin
                            sym_next = sym_reg + 8'd1;
                        end
                    end else begin
                        pos_next = pos_reg + 1'b1;
                    end
                end
                default: state_next = WAIT_A;
            endcase
        end

        flag_next = (state_next == WAIT_A);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= WAIT_A;
            gap_reg     <= 8'd0;
            pos_reg     <= '0;
            sym_reg     <= 8'd0;
            flag_reg    <= 1'b1;
            start_reg   <= 1'b0;
            dv_reg      <= 1'b0;
            sym_idx_reg <= 8'd0;
            smp_idx_reg <= 8'd0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gap_reg     <= gap_next;
            pos_reg     <= pos_next;
            sym_reg     <= sym_next;
            flag_reg    <= flag_next;
            start_reg   <= start_next;
            dv_reg      <= dv_next;
            sym_idx_reg <= sym_idx_next;
            smp_idx_reg <= smp_idx_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
        end
    end

    assign o_flaf_wayt_data = flag_reg;
    assign o_frame_start    = start_reg;
    assign o_data_valid     = dv_reg;
    assign o_sym_idx        = sym_idx_reg;
    assign o_smp_idx        = smp_idx_reg;
    assign o_frame_done     = done_reg;
    assign o_err_timeout    = timeout_reg;

endmodule

// File: tb/tb_ofdm_frame_sync_ctrl.sv
// ============================================================================
// tb_ofdm_frame_sync_ctrl
//
// Self-checking bench for ofdm_frame_sync_ctrl with default parameters.
// A small reference model tracks "samples since A" and "frame sample number"
// and derives symbol/sample indices arithmetically; every cycle the DUT
// outputs are compared against it. A vector table covers the reset/idle
// behaviour, hand-written sequences cover the frame-level corner cases, and a
// randomized run exercises arbitrary valid/en/A/B patterns.
// ============================================================================
module tb_ofdm_frame_sync_ctrl;

    localparam int SYM_LEN = 64;
    localparam int CP_LEN  = 16;
    localparam int N_SYM   = 8;
    localparam int AB_MIN  = 60;
    localparam int AB_MAX  = 68;
`ifdef OFDM_FRAME_CP_STRIP_EN
    localparam int PER = CP_LEN + SYM_LEN;
    localparam int CP  = CP_LEN;
`else
    localparam int PER = SYM_LEN;
    localparam int CP  = 0;
`endif

    localparam int M_IDLE = 0;  // waiting for A
    localparam int M_SRCH = 1;  // waiting for B
    localparam int M_FRM  = 2;  // inside the frame

    logic       clk = 1'b0;
    logic       rst_n, en, valid, pa, pb;
    logic       o_flag, o_start, o_dv, o_done, o_to;
    logic [7:0] o_sym, o_smp;

    always #5 clk = ~clk;

    ofdm_frame_sync_ctrl #(
        .SYM_LEN(SYM_LEN), .CP_LEN(CP_LEN), .N_SYM(N_SYM),
        .AB_MIN(AB_MIN), .AB_MAX(AB_MAX)
    ) dut (
        .clk(clk), .reset(rst_n), .en(en), .valid(valid),
        .find_preamble_a(pa), .find_preamble_b(pb),
        .o_flaf_wayt_data(o_flag), .o_frame_start(o_start),
        .o_data_valid(o_dv), .o_sym_idx(o_sym), .o_smp_idx(o_smp),
        .o_frame_done(o_done), .o_err_timeout(o_to)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state and expected outputs
    int  m_mode = M_IDLE;
    int  m_dist = 0;
    int  m_fs   = 0;
    bit  e_flag = 1, e_start = 0, e_dv = 0, e_done = 0, e_to = 0;
    int  e_sym = 0, e_smp = 0;

    // Aggregate event counters for the sequence-level checks
    int cnt_start, cnt_dv, cnt_done, cnt_to;
    int done_sym, done_smp;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit e,
                         input bit a, input bit b);
        int k;
        int p;
        e_start = 0; e_dv = 0; e_done = 0; e_to = 0;
        if (!r) begin
            m_mode = M_IDLE; m_dist = 0; m_fs = 0; e_sym = 0; e_smp = 0;
        end else if (v && e) begin
            if (m_mode == M_IDLE) begin
                if (a) begin m_mode = M_SRCH; m_dist = 0; end
            end else if (m_mode == M_SRCH) begin
                k = m_dist + 1;
                if (b && k >= AB_MIN && k <= AB_MAX) begin
                    m_mode = M_FRM; m_fs = 0; e_start = 1;
                end else if (a) begin
                    m_dist = 0;
                end else if (k == AB_MAX) begin
                    m_mode = M_IDLE; e_to = 1;
                end else begin
                    m_dist = k;
                end
            end else begin
                p = m_fs % PER;
                if (p >= CP) begin
                    e_dv = 1; e_sym = m_fs / PER; e_smp = p - CP;
                end
                m_fs++;
                if (m_fs == N_SYM * PER) begin
                    e_done = 1; m_mode = M_IDLE;
                end
            end
        end
        e_flag = (m_mode == M_IDLE);
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit r, input bit v, input bit e,
                        input bit a, input bit b);
        rst_n = r; valid = v; en = e; pa = a; pb = b;
        @(posedge clk);
        #1;
        model(r, v, e, a, b);
        check("flag", int'(o_flag), int'(e_flag));
        check("start", int'(o_start), int'(e_start));
        check("data_valid", int'(o_dv), int'(e_dv));
        check("done", int'(o_done), int'(e_done));
        check("timeout", int'(o_to), int'(e_to));
        check("sym_idx", int'(o_sym), e_sym);
        check("smp_idx", int'(o_smp), e_smp);
        if (o_start) cnt_start++;
        if (o_dv) cnt_dv++;
        if (o_to) cnt_to++;
        if (o_done) begin
            cnt_done++; done_sym = int'(o_sym); done_smp = int'(o_smp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 1, 0, 0);
    endtask

    task automatic clr_cnt();
        cnt_start = 0; cnt_dv = 0; cnt_done = 0; cnt_to = 0;
        done_sym = -1; done_smp = -1;
    endtask

    typedef struct {
        bit r, v, e, a, b;
        bit f, s, dv, to;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rst_n = 1'b0; valid = 1'b0; en = 1'b0; pa = 1'b0; pb = 1'b0;
        clr_cnt();

        //          r  v  e  a  b   f  s  dv to
        tbl[0] = '{0, 0, 0, 0, 0,  1, 0, 0, 0};  // reset
        tbl[1] = '{1, 1, 1, 0, 0,  1, 0, 0, 0};  // idle sample
        tbl[2] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};  // A with en low: ignored
        tbl[3] = '{1, 0, 1, 1, 0,  1, 0, 0, 0};  // A with valid low: ignored
        tbl[4] = '{1, 1, 1, 0, 1,  1, 0, 0, 0};  // B while waiting for A
        tbl[5] = '{1, 1, 1, 1, 0,  0, 0, 0, 0};  // A accepted
        tbl[6] = '{1, 1, 1, 0, 1,  0, 0, 0, 0};  // B at k=1: too early
        tbl[7] = '{0, 1, 1, 0, 0,  1, 0, 0, 0};  // reset from WAIT_B
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].e, tbl[i].a, tbl[i].b);
            check("tbl_flag", int'(o_flag), int'(tbl[i].f));
            check("tbl_start", int'(o_start), int'(tbl[i].s));
            check("tbl_dv", int'(o_dv), int'(tbl[i].dv));
            check("tbl_to", int'(o_to), int'(tbl[i].to));
        end

        // Full frame with B at k=64
        clr_cnt();
        step(1, 1, 1, 1, 0);
        idle(63);
        step(1, 1, 1, 0, 1);
        idle(N_SYM * PER + 10);
        check("t1_starts", cnt_start, 1);
        check("t1_dv_total", cnt_dv, 512);
        check("t1_done", cnt_done, 1);
        check("t1_done_sym", done_sym, 7);
        check("t1_done_smp", done_smp, 63);
        check("t1_flag_back", int'(o_flag), 1);

        // A without B: timeout
        clr_cnt();
        step(1, 1, 1, 1, 0);
        idle(80);
        check("t2_timeout", cnt_to, 1);
        check("t2_no_dv", cnt_dv, 0);

        // Early B ignored, in-window B starts the frame
        clr_cnt();
        step(1, 1, 1, 1, 0);
        idle(39);
        step(1, 1, 1, 0, 1);
        idle(23);
        step(1, 1, 1, 0, 1);
        idle(N_SYM * PER + 10);
        check("t3_starts", cnt_start, 1);
        check("t3_dv_total", cnt_dv, 512);
        check("t3_no_timeout", cnt_to, 0);

        // Re-anchor on second A; B at k=34 ignored; timeout from second A
        clr_cnt();
        step(1, 1, 1, 1, 0);
        idle(29);
        step(1, 1, 1, 1, 0);
        idle(33);
        step(1, 1, 1, 0, 1);
        idle(40);
        check("t4_no_start", cnt_start, 0);
        check("t4_timeout", cnt_to, 1);

        // Gaps in valid and en inside DATA
        clr_cnt();
        step(1, 1, 1, 1, 0);
        idle(63);
        step(1, 1, 1, 0, 1);
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 >= 10 && i % 50 <= 12)      step(1, 0, 1, 0, 0);
            else if (i % 50 >= 13 && i % 50 <= 14) step(1, 1, 0, 0, 0);
            else                                   step(1, 1, 1, 0, 0);
        end
        check("t5_dv_total", cnt_dv, 512);
        check("t5_done", cnt_done, 1);

        // Reset in the middle of symbol 3, then a clean frame
        clr_cnt();
        step(1, 1, 1, 1, 0);
        idle(63);
        step(1, 1, 1, 0, 1);
        idle(3 * PER + 5);
        check("t6_in_sym3", int'(o_sym), 3);
        step(0, 1, 1, 0, 0);
        check("t6_rst_flag", int'(o_flag), 1);
        check("t6_rst_dv", int'(o_dv), 0);
        check("t6_rst_sym", int'(o_sym), 0);
        step(1, 1, 1, 1, 0);
        idle(63);
        step(1, 1, 1, 0, 1);
        begin
            int n = 0;
            step(1, 1, 1, 0, 0);
            while (!o_dv && n < 100) begin
                step(1, 1, 1, 0, 0);
                n++;
            end
            check("t6_first_dv_seen", int'(o_dv), 1);
            check("t6_first_sym", int'(o_sym), 0);
            check("t6_first_smp", int'(o_smp), 0);
        end
        idle(N_SYM * PER + 10);

        // Randomized stimulus against the model
        clr_cnt();
        for (int i = 0; i < 20000; i++) begin
            bit r, v, e, a, b;
            r = ($urandom_range(0, 1999) != 0);
            v = ($urandom_range(0, 9) < 8);
            e = ($urandom_range(0, 9) < 9);
            a = ($urandom_range(0, 99) == 0);
            b = ($urandom_range(0, 7) == 0);
            step(r, v, e, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
